screen_readback: RTL and testbench

Bus-side responder for the text screen. It keeps a shadow copy of the 2048-cell text/attribute buffer so the CPU can read back cells over `screen_ren`, and forwards every cell write to `VGAMod` so the shadow and the display never diverge. It also provides a hardware clear-screen engine. It sits between `bus` (`screen_ren`/`screen_wen`) and the `VGAMod` write port, in the CPU clock domain.

---
 rtl/screen_pkg.sv | 27 ++
 rtl/text_shadow_ram.sv | 36 +++
 rtl/screen_readback.sv | 104 ++++++++++
 tb/tb_screen_readback.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// screen_pkg: shared constants and types for the text-screen readback block.
//   ADDR_BITS  - cell index width
//   CELLS      - number of text cells
//   LAST_CELL  - index of the final cell written by a clear
//   BLANK_CHAR - character code used by the clear fill
//   state_t    - controller states
//   cell_t     - one screen cell, {attr, text}
package screen_pkg;

    localparam int ADDR_BITS = 11;
    localparam int CELLS     = 2 ** ADDR_BITS;

    localparam logic [ADDR_BITS-1:0] LAST_CELL  = ADDR_BITS'(CELLS - 1);
    localparam logic [7:0]           BLANK_CHAR = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        CLEAR
    } state_t;

    typedef struct packed {
        logic [7:0] attr;
        logic [7:0] text;
    } cell_t;

endpackage

// File: rtl/text_shadow_ram.sv
// text_shadow_ram: single-port CELLS x 16 shadow of the screen buffer, synchronous read, write-first.
//   clk   - clock
//   reset - clears the read-data register only; cell contents are not initialised
//   re    - read enable; q is updated only when re=1, otherwise it holds
//   we    - write enable
//   addr  - cell index shared by read and write
//   wdata - cell to write
//   q     - registered read data (returns wdata when re and we coincide)
module text_shadow_ram
    import screen_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 re,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  cell_t                wdata,
    output cell_t                q
);

    cell_t mem [CELLS];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    // The read register only moves on an actual read so the bus sees held data.
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (re)
            q <= we ? wdata : mem[addr];
    end

endmodule

// File: rtl/screen_readback.sv
// screen_readback: bus responder holding a shadow of the text screen, mirroring writes to VGAMod, with a clear-screen engine.
//   clk, reset          - CPU clock, synchronous active-high reset
//   ren / ready / rdata - read request, one-cycle acknowledge, {attr,text,attr,text}
//   wen, addr, wdata_*  - single-cycle cell write
//   clr_start, clr_attr - start a full-screen fill with the given attribute
//   clr_busy            - high while the fill runs
//   vga_*               - registered write port towards VGAMod
module screen_readback
    import screen_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ren,
    input  logic                 wen,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [7:0]           wdata_text,
    input  logic [7:0]           wdata_attr,
    input  logic                 clr_start,
    input  logic [7:0]           clr_attr,
    output logic [31:0]          rdata,
    output logic                 ready,
    output logic                 clr_busy,
    output logic                 vga_wen,
    output logic [ADDR_BITS-1:0] vga_waddr,
    output logic [7:0]           vga_text,
    output logic [7:0]           vga_attr
);

    state_t                state;
    logic [ADDR_BITS-1:0]  cnt;
    logic [7:0]            fill_attr;
    logic                  fill;
    logic                  rd_fire;
    logic                  ram_we;
    logic [ADDR_BITS-1:0]  ram_addr;
    cell_t                 ram_wdata;
    cell_t                 ram_q;

    // The fill owns the RAM port for the whole clear; bus writes are dropped then.
    // Gating with reset keeps an aborted fill from writing one extra cell.
    always_comb begin
        fill      = (state == CLEAR);
        rd_fire   = (state == IDLE) && ren && !clr_start;
        ram_we    = !reset && (fill || wen);
        ram_addr  = fill ? cnt : addr;
        ram_wdata = fill ? {fill_attr, BLANK_CHAR} : {wdata_attr, wdata_text};
    end

    text_shadow_ram u_ram (
        .clk   (clk),
        .reset (reset),
        .re    (rd_fire),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    assign rdata = {ram_q, ram_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            fill_attr <= '0;
            ready     <= 1'b0;
            clr_busy  <= 1'b0;
            vga_wen   <= 1'b0;
            vga_waddr <= '0;
            vga_text  <= '0;
            vga_attr  <= '0;
        end else begin
            ready   <= rd_fire;
            vga_wen <= ram_we;
            if (ram_we) begin
                vga_waddr <= ram_addr;
                vga_text  <= ram_wdata.text;
                vga_attr  <= ram_wdata.attr;
            end
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        fill_attr <= clr_attr;
                        cnt       <= '0;
                        clr_busy  <= 1'b1;
                        state     <= CLEAR;
                    end else if (ren) begin
                        state <= RESP;
                    end
                end
                RESP: state <= IDLE;
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CELL) begin
                        clr_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_screen_readback.sv
// tb_screen_readback: directed self-checking bench for screen_readback.
module tb_screen_readback;

    logic        clk = 1'b0;
    logic        reset;
    logic        ren;
    logic        wen;
    logic [10:0] addr;
    logic [7:0]  wdata_text;
    logic [7:0]  wdata_attr;
    logic        clr_start;
    logic [7:0]  clr_attr;
    logic [31:0] rdata;
    logic        ready;
    logic        clr_busy;
    logic        vga_wen;
    logic [10:0] vga_waddr;
    logic [7:0]  vga_text;
    logic [7:0]  vga_attr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    screen_readback dut (
        .clk        (clk),
        .reset      (reset),
        .ren        (ren),
        .wen        (wen),
        .addr       (addr),
        .wdata_text (wdata_text),
        .wdata_attr (wdata_attr),
        .clr_start  (clr_start),
        .clr_attr   (clr_attr),
        .rdata      (rdata),
        .ready      (ready),
        .clr_busy   (clr_busy),
        .vga_wen    (vga_wen),
        .vga_waddr  (vga_waddr),
        .vga_text   (vga_text),
        .vga_attr   (vga_attr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ren = 0; wen = 0; addr = 0; wdata_text = 0; wdata_attr = 0; clr_start = 0; clr_attr = 0;
        tick();
        tick();
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if (clr_busy !== 1'b0) begin failures++; $display("FAIL reset_clr_busy got=%b exp=0", clr_busy); end
        checks++; if ({vga_wen, vga_waddr, vga_text, vga_attr} !== 28'h0) begin failures++; $display("FAIL reset_vga got=%b/%h/%h/%h exp=0", vga_wen, vga_waddr, vga_text, vga_attr); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        wen = 1; addr = 11'h005; wdata_text = 8'h41; wdata_attr = 8'h1F;
        tick();
        wen = 0;
        checks++; if ({vga_wen, vga_waddr, vga_text, vga_attr} !== {1'b1, 11'h005, 8'h41, 8'h1F}) begin failures++; $display("FAIL wr_vga got=%b/%h/%h/%h exp=1/005/41/1f", vga_wen, vga_waddr, vga_text, vga_attr); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL wr_no_ready got=%b exp=0", ready); end
        tick();
        checks++; if (vga_wen !== 1'b0) begin failures++; $display("FAIL wr_vga_pulse got=%b exp=0", vga_wen); end
        ren = 1;
        tick();
        ren = 0;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rd_ready got=%b exp=1", ready); end
        checks++; if (rdata !== 32'h1F411F41) begin failures++; $display("FAIL rd_data got=%h exp=1f411f41", rdata); end
        tick();
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rd_ready_drop got=%b exp=0", ready); end
        checks++; if (rdata !== 32'h1F411F41) begin failures++; $display("FAIL rd_hold got=%h exp=1f411f41", rdata); end
    endtask

    task automatic test_simultaneous();
        ren = 1; wen = 1; addr = 11'h7FF; wdata_text = 8'h5A; wdata_attr = 8'h07;
        tick();
        ren = 0; wen = 0;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL sim_ready got=%b exp=1", ready); end
        checks++; if (rdata !== 32'h075A075A) begin failures++; $display("FAIL sim_data got=%h exp=075a075a", rdata); end
        checks++; if ({vga_wen, vga_waddr} !== {1'b1, 11'h7FF}) begin failures++; $display("FAIL sim_vga got=%b/%h exp=1/7ff", vga_wen, vga_waddr); end
        tick();
    endtask

    task automatic read_cell(input logic [10:0] a, input logic [31:0] exp, input string name);
        ren = 1; addr = a;
        tick();
        ren = 0;
        checks++; if (ready !== 1'b1 || rdata !== exp) begin failures++; $display("FAIL %s got=%b/%h exp=1/%h", name, ready, rdata, exp); end
        tick();
    endtask

    task automatic test_full_clear();
        int busy_cycles;
        int strobes;
        int bad;
        int j;
        clr_attr = 8'h70; clr_start = 1;
        tick();
        clr_start = 0;
        checks++; if (clr_busy !== 1'b1 || vga_wen !== 1'b0) begin failures++; $display("FAIL clr_start busy/wen got=%b/%b exp=1/0", clr_busy, vga_wen); end
        busy_cycles = 1; strobes = 0; bad = 0; j = 0;
        while (clr_busy === 1'b1 && j < 3000) begin
            tick();
            j++;
            if (vga_wen === 1'b1) strobes++;
            if (vga_wen !== 1'b1 || vga_waddr !== 11'(j - 1) || vga_text !== 8'h20 || vga_attr !== 8'h70) bad++;
            if (clr_busy === 1'b1) busy_cycles++;
        end
        checks++; if (busy_cycles != 2048) begin failures++; $display("FAIL clr_busy_len got=%0d exp=2048", busy_cycles); end
        checks++; if (strobes != 2048) begin failures++; $display("FAIL clr_strobes got=%0d exp=2048", strobes); end
        checks++; if (bad != 0) begin failures++; $display("FAIL clr_strobe_content got=%0d bad exp=0", bad); end
        tick();
        checks++; if (vga_wen !== 1'b0) begin failures++; $display("FAIL clr_end_wen got=%b exp=0", vga_wen); end
        read_cell(11'h000, 32'h70207020, "clr_rd_000");
        read_cell(11'h7FF, 32'h70207020, "clr_rd_7ff");
        read_cell(11'h005, 32'h70207020, "clr_rd_005");
    endtask

    task automatic test_traffic_during_clear();
        int bad;
        int j;
        clr_attr = 8'h70; clr_start = 1;
        tick();
        clr_start = 0;
        repeat (10) tick();
        wen = 1; addr = 11'h003; wdata_text = 8'h33; wdata_attr = 8'h44;
        tick();
        wen = 0;
        checks++; if (vga_waddr === 11'h003 || vga_text !== 8'h20) begin failures++; $display("FAIL clr_wen_drop got=%h/%h exp=fill/20", vga_waddr, vga_text); end
        ren = 1; addr = 11'h003; clr_start = 1; clr_attr = 8'h99;
        bad = 0; j = 0;
        while (clr_busy === 1'b1 && j < 3000) begin
            tick();
            j++;
            if (ready !== 1'b0 || vga_attr !== 8'h70) bad++;
        end
        clr_start = 0;
        checks++; if (bad != 0 || j >= 3000) begin failures++; $display("FAIL clr_ren_blocked got=%0d bad/%0d cycles exp=0", bad, j); end
        tick();
        ren = 0;
        checks++; if (ready !== 1'b1 || rdata !== 32'h70207020) begin failures++; $display("FAIL clr_ren_served got=%b/%h exp=1/70207020", ready, rdata); end
        checks++; if (clr_busy !== 1'b0) begin failures++; $display("FAIL clr_start_ignored got=%b exp=0", clr_busy); end
        tick();
    endtask

    task automatic test_reset_mid_clear();
        int j;
        clr_attr = 8'h11; clr_start = 1;
        tick();
        clr_start = 0;
        repeat (100) tick();
        checks++; if (vga_waddr !== 11'd99 || vga_attr !== 8'h11) begin failures++; $display("FAIL rst_clr_pos got=%h/%h exp=063/11", vga_waddr, vga_attr); end
        reset = 1;
        tick();
        reset = 0;
        checks++; if (clr_busy !== 1'b0 || vga_wen !== 1'b0) begin failures++; $display("FAIL rst_clr_abort got=%b/%b exp=0/0", clr_busy, vga_wen); end
        tick();
        checks++; if (vga_wen !== 1'b0) begin failures++; $display("FAIL rst_clr_idle got=%b exp=0", vga_wen); end
        read_cell(11'd99, 32'h11201120, "rst_rd_99");
        read_cell(11'd100, 32'h70207020, "rst_rd_100");
        clr_attr = 8'h22; clr_start = 1;
        tick();
        clr_start = 0;
        checks++; if (vga_wen !== 1'b0 || clr_busy !== 1'b1) begin failures++; $display("FAIL rst_restart_first got=%b/%b exp=0/1", vga_wen, clr_busy); end
        tick();
        checks++; if ({vga_wen, vga_waddr, vga_attr} !== {1'b1, 11'h000, 8'h22}) begin failures++; $display("FAIL rst_restart_addr got=%b/%h/%h exp=1/000/22", vga_wen, vga_waddr, vga_attr); end
        j = 0;
        while (clr_busy === 1'b1 && j < 3000) begin
            tick();
            j++;
        end
        checks++; if (j >= 3000) begin failures++; $display("FAIL rst_restart_done got=%0d cycles exp<3000", j); end
        tick();
    endtask

    task automatic test_ready_hygiene();
        logic [2:0] seen;
        ren = 1; addr = 11'h000;
        tick(); seen[2] = ready;
        tick(); seen[1] = ready;
        tick(); seen[0] = ready;
        ren = 0;
        checks++; if (seen !== 3'b101) begin failures++; $display("FAIL hyg_pulses got=%b exp=101", seen); end
        checks++; if (rdata !== 32'h22202220) begin failures++; $display("FAIL hyg_data got=%h exp=22202220", rdata); end
        tick(); seen[1] = ready;
        tick(); seen[0] = ready;
        checks++; if (seen[1:0] !== 2'b00) begin failures++; $display("FAIL hyg_idle got=%b exp=00", seen[1:0]); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_simultaneous();
        test_full_clear();
        test_traffic_during_clear();
        test_reset_mid_clear();
        test_ready_hygiene();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
